// File: rtl/axis_block_accumulator.sv
// AXIS block accumulator: sums fixed blocks of 2^BLOCK_SIZE_LOG unsigned samples and emits sum and mean.
// Build option: define AXIS_BLOCK_ACC_ROUND_EN for a round-half-up mean (default build truncates).
module axis_block_accumulator #(
    parameter int DATA_WIDTH     = 10,
    parameter int BLOCK_SIZE_LOG = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 input_valid,
    input  logic [DATA_WIDTH-1:0]                input_data,
    output logic                                 input_ready,
    output logic                                 output_valid,
    output logic [DATA_WIDTH+BLOCK_SIZE_LOG-1:0] output_sum,
    output logic [DATA_WIDTH-1:0]                output_mean,
    input  logic                                 output_ready
);

    localparam int SW    = DATA_WIDTH + BLOCK_SIZE_LOG;
    localparam int CNT_W = (BLOCK_SIZE_LOG == 0) ? 1 : BLOCK_SIZE_LOG;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << BLOCK_SIZE_LOG) - 1);

    logic [SW-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]         out_sum_q, out_sum_d;
    logic [DATA_WIDTH-1:0] out_mean_q, out_mean_d;
    logic                  out_valid_q, out_valid_d;

    logic                  last_sample;
    logic                  in_fire;
    logic                  out_fire;
    logic [SW-1:0]         blk_sum;
    logic [DATA_WIDTH-1:0] blk_mean;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and input_ready looks combinationally at output_ready
    // so the final sample of a block can land in the same cycle the held result leaves.
    assign last_sample = (cnt_q == CNT_LAST);
    assign input_ready = !last_sample || !out_valid_q || output_ready;
    assign in_fire     = input_valid && input_ready;
    assign out_fire    = out_valid_q && output_ready;
    assign blk_sum     = acc_q + SW'(input_data);

`ifdef AXIS_BLOCK_ACC_ROUND_EN
    // Adding half an LSB before the shift equals adding the first discarded bit after it.
    if (BLOCK_SIZE_LOG > 0) begin : g_round
        assign blk_mean = blk_sum[SW-1:BLOCK_SIZE_LOG] + DATA_WIDTH'(blk_sum[BLOCK_SIZE_LOG-1]);
    end else begin : g_no_round
        assign blk_mean = blk_sum[DATA_WIDTH-1:0];
    end
`else
    assign blk_mean = blk_sum[SW-1:BLOCK_SIZE_LOG];
`endif

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_mean_d  = out_mean_q;
        out_valid_d = out_valid_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (in_fire) begin
            if (last_sample) begin
                out_sum_d   = blk_sum;
                out_mean_d  = blk_mean;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = blk_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_mean_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_mean_q  <= out_mean_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign output_valid = out_valid_q;
    assign output_sum   = out_sum_q;
    assign output_mean  = out_mean_q;

endmodule
